rgb_threshold_multi: RTL and testbench
======================================

// Module: rgb_threshold_multi
// PURPOSE
//  Multi-window colour threshold on a parallel RGB video stream (RGB565 by default).
//  Compares every pixel against NUM_WIN runtime-programmable RGB boxes and emits one
//  binary mask bit per window, with syncs delayed to match.
//  Accumulates per-window hit count and bounding box each frame, reported at the next
//  frame start. Sits after the camera/RGB capture stage, feeding the blob/target tracker.
// PARAMETERS
//  R_W      5     red component width (bits)
//  G_W      6     green component width
//  B_W      5     blue component width
//  NUM_WIN  2     number of independent threshold windows (1..8)
//  X_W      11    column counter width (max line length 2^X_W-1)
//  Y_W      11    row counter width
//  CNT_W    22    hit counter width (saturating)
// PORTS
//  clk         in   1                  pixel clock
//  rst         in   1                  synchronous reset, active-high
//  in_data     in   R_W+G_W+B_W        pixel, {R,G,B}, R in MSBs
//  in_hs       in   1                  hsync (passed through only)
//  in_vs       in   1                  vsync, active-high
//  in_de       in   1                  data enable, pixel valid when 1
//  cfg_we      in   1                  config write strobe
//  cfg_addr    in   $clog2(NUM_WIN)+3  {win, field}
//  cfg_wdata   in   8                  config value, LSBs used
//  thr_data    out  NUM_WIN            mask, bit w = pixel inside window w
//  thr_hs      out  1                  in_hs delayed 2
//  thr_vs      out  1                  in_vs delayed 2
//  thr_de      out  1                  in_de delayed 2
//  stat_valid  out  1                  1-cycle pulse, stats of finished frame valid
//  stat_count  out  NUM_WIN*CNT_W      hit count per window
//  stat_bbox   out  NUM_WIN*(2*X_W+2*Y_W)  per window {xmin,xmax,ymin,ymax}
// BEHAVIOUR
//  Reset: all outputs 0; shadow/active thresholds min=0, max=all-ones; enables=0;
//   x=y=0; accumulators cleared (count 0, xmin/ymin all-ones, xmax/ymax 0).
//  Config fields: 0 rmin, 1 rmax, 2 gmin, 3 gmax, 4 bmin, 5 bmax, 6 enable (bit0).
//   Field 7 or win>=NUM_WIN: write ignored. Writes land in shadow regs only.
//  Frame start (FS) = rising edge of in_vs (registered compare, so FS is seen 1 cycle late).
//   On FS: shadow->active copy; accumulators -> stat_* outputs; stat_valid pulses once;
//   accumulators cleared; y=0. A cfg write in the same cycle as FS lands in shadow and
//   takes effect at the next FS.
//  Pixel path, latency 2 cycles (data and syncs identical):
//   stage1 registers in_data/syncs; stage2 evaluates the compare, which is inclusive
//   (min<=c<=max) on all three components and ANDed with enable; the result is gated
//   by the stage1 de. Result: thr_data=0 whenever thr_de=0.
//   min>max: the window never matches (no wrap).
//  Position: x counts de pixels in a line starting at 0; on de falling edge x=0, y+=1.
//   x and y saturate at all-ones; they never wrap.
//  Accumulate, per window on a hit: count+=1 (saturates at 2^CNT_W-1); xmin/xmax/ymin/ymax
//   are updated with min/max of (x,y).
//  A frame with no hits reports count=0, xmin=ymin=all-ones, xmax=ymax=0.
//  Reset mid-frame: the pipeline flushes, no stat_valid fires, and accumulation starts
//   at the next FS. Until that FS, accumulation runs but is discarded at the FS.
//  stat_* hold between pulses. The first FS after reset reports the empty/partial frame.
// TESTING
//  1 reset, enable win0 with R[0..6] G[0..12] B[0..6]; pixel 16'h0000, then 16'hFFFF
//    -> thr_data[0] = 1, then 0, each 2 cycles after input; thr_de/hs/vs delayed 2.
//  2 boundary: pixel R=6,G=12,B=6 -> hit; R=7 -> miss; window with rmin=9,rmax=3 -> never hits.
//  3 4x3 frame, hits at (1,0) and (3,2) -> next FS: stat_valid 1 cycle,
//    count=2, bbox {1,3,0,2}.
//  4 cfg write rmax=31 mid-frame -> mask unchanged until next FS, changes after it.
//  5 frame with no hits -> count 0, xmin=ymin=2047, xmax=ymax=0;
//    hits with de low -> ignored.
//  6 rst asserted mid-frame for 1 cycle -> outputs 0 next cycle; no stat_valid
//    until the following FS; CNT_W=3 with 10 hits -> count=7.

Source files
------------

// File: rtl/rgb_threshold_multi.sv
// rgb_threshold_multi: per-pixel RGB box threshold against NUM_WIN windows,
// with per-window hit count and bounding box reported at each frame start.

module rgb_thr_win #(
  parameter int R_W   = 5,
  parameter int G_W   = 6,
  parameter int B_W   = 5,
  parameter int X_W   = 11,
  parameter int Y_W   = 11,
  parameter int CNT_W = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_field,
  input  logic [7:0]             cfg_wdata,
  input  logic                   fs,
  input  logic [R_W+G_W+B_W-1:0] pix,
  input  logic                   pix_de,
  input  logic [X_W-1:0]         x,
  input  logic [Y_W-1:0]         y,
  output logic                   hit,
  output logic [CNT_W-1:0]       acc_count,
  output logic [2*X_W+2*Y_W-1:0] acc_bbox
);
  typedef struct packed {
    logic [R_W-1:0] rmin, rmax;
    logic [G_W-1:0] gmin, gmax;
    logic [B_W-1:0] bmin, bmax;
    logic           en;
  } win_cfg_t;

  localparam win_cfg_t CFG_RST = '{'0, '1, '0, '1, '0, '1, 1'b0};

  win_cfg_t       shadow, active;
  logic [R_W-1:0] r;
  logic [G_W-1:0] g;
  logic [B_W-1:0] b;
  logic [X_W-1:0] xmin, xmax;
  logic [Y_W-1:0] ymin, ymax;
  logic           unused_ok;

  assign unused_ok = &{1'b0, cfg_wdata};
  assign r = pix[R_W+G_W+B_W-1 -: R_W];
  assign g = pix[G_W+B_W-1 -: G_W];
  assign b = pix[B_W-1:0];

  // Inclusive compare; an inverted range (min>max) simply never matches.
  assign hit = pix_de && active.en &&
               r >= active.rmin && r <= active.rmax &&
               g >= active.gmin && g <= active.gmax &&
               b >= active.bmin && b <= active.bmax;
  assign acc_bbox = {xmin, xmax, ymin, ymax};

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= CFG_RST;
      active <= CFG_RST;
    end else begin
      if (fs) active <= shadow;
      if (cfg_we) begin
        case (cfg_field)
          3'd0:    shadow.rmin <= cfg_wdata[R_W-1:0];
          3'd1:    shadow.rmax <= cfg_wdata[R_W-1:0];
          3'd2:    shadow.gmin <= cfg_wdata[G_W-1:0];
          3'd3:    shadow.gmax <= cfg_wdata[G_W-1:0];
          3'd4:    shadow.bmin <= cfg_wdata[B_W-1:0];
          3'd5:    shadow.bmax <= cfg_wdata[B_W-1:0];
          3'd6:    shadow.en   <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fs) begin
      acc_count <= '0;
      xmin      <= '1;
      xmax      <= '0;
      ymin      <= '1;
      ymax      <= '0;
    end else if (hit) begin
      if (acc_count != '1) acc_count <= acc_count + 1'b1;
      if (x < xmin) xmin <= x;
      if (x > xmax) xmax <= x;
      if (y < ymin) ymin <= y;
      if (y > ymax) ymax <= y;
    end
  end
endmodule

module rgb_threshold_multi #(
  parameter int R_W     = 5,
  parameter int G_W     = 6,
  parameter int B_W     = 5,
  parameter int NUM_WIN = 2,
  parameter int X_W     = 11,
  parameter int Y_W     = 11,
  parameter int CNT_W   = 22
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [R_W+G_W+B_W-1:0]            in_data,
  input  logic                              in_hs,
  input  logic                              in_vs,
  input  logic                              in_de,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_WIN)+2:0]        cfg_addr,
  input  logic [7:0]                        cfg_wdata,
  output logic [NUM_WIN-1:0]                thr_data,
  output logic                              thr_hs,
  output logic                              thr_vs,
  output logic                              thr_de,
  output logic                              stat_valid,
  output logic [NUM_WIN*CNT_W-1:0]          stat_count,
  output logic [NUM_WIN*(2*X_W+2*Y_W)-1:0]  stat_bbox
);
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int AW    = $clog2(NUM_WIN) + 3;
  localparam int BB_W  = 2*X_W + 2*Y_W;

  logic [PIX_W-1:0]                 s1_data;
  logic                             s1_hs, s1_vs, s1_de;
  logic                             fs;
  logic [X_W-1:0]                   x;
  logic [Y_W-1:0]                   y;
  logic [AW-1:0]                    cfg_win;
  logic [NUM_WIN-1:0]               hit;
  logic [NUM_WIN-1:0][CNT_W-1:0]    acc_count;
  logic [NUM_WIN-1:0][BB_W-1:0]     acc_bbox;

  assign cfg_win = cfg_addr >> 3;
  // Rising vsync seen between stage1 and stage2 registers.
  assign fs = s1_vs & ~thr_vs;

  for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
    rgb_thr_win #(
      .R_W(R_W), .G_W(G_W), .B_W(B_W), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)
    ) u_win (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we && cfg_win == AW'(w)),
      .cfg_field (cfg_addr[2:0]),
      .cfg_wdata (cfg_wdata),
      .fs        (fs),
      .pix       (s1_data),
      .pix_de    (s1_de),
      .x         (x),
      .y         (y),
      .hit       (hit[w]),
      .acc_count (acc_count[w]),
      .acc_bbox  (acc_bbox[w])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_de    <= 1'b0;
      thr_data <= '0;
      thr_hs   <= 1'b0;
      thr_vs   <= 1'b0;
      thr_de   <= 1'b0;
    end else begin
      s1_data  <= in_data;
      s1_hs    <= in_hs;
      s1_vs    <= in_vs;
      s1_de    <= in_de;
      thr_data <= hit;
      thr_hs   <= s1_hs;
      thr_vs   <= s1_vs;
      thr_de   <= s1_de;
    end
  end

  // Position of the pixel currently in stage1; thr_de is the previous stage1 de.
  always_ff @(posedge clk) begin
    if (rst || fs) begin
      x <= '0;
      y <= '0;
    end else if (s1_de) begin
      if (x != '1) x <= x + 1'b1;
    end else if (thr_de) begin
      x <= '0;
      if (y != '1) y <= y + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_valid <= 1'b0;
      stat_count <= '0;
      stat_bbox  <= '0;
    end else begin
      stat_valid <= fs;
      if (fs) begin
        stat_count <= acc_count;
        stat_bbox  <= acc_bbox;
      end
    end
  end
endmodule

// File: tb/tb_rgb_threshold_multi.sv
// Self-checking bench for rgb_threshold_multi: directed scenarios plus random
// frames, all compared against a frame-level behavioural model.
module tb_rgb_threshold_multi;
  localparam int NW = 2;
  localparam int CW = 22;
  localparam int BB = 44;

  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] in_data = '0;
  logic in_hs = 0, in_vs = 0, in_de = 0, cfg_we = 0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;

  logic [NW-1:0] thr_data, thr_data3;
  logic thr_hs, thr_vs, thr_de, thr_hs3, thr_vs3, thr_de3;
  logic stat_valid, stat_valid3;
  logic [NW*CW-1:0] stat_count;
  logic [NW*3-1:0]  stat_count3;
  logic [NW*BB-1:0] stat_bbox, stat_bbox3;

  always #5 clk = ~clk;

  rgb_threshold_multi dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .thr_data(thr_data), .thr_hs(thr_hs), .thr_vs(thr_vs), .thr_de(thr_de),
    .stat_valid(stat_valid), .stat_count(stat_count), .stat_bbox(stat_bbox));

  rgb_threshold_multi #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .thr_data(thr_data3), .thr_hs(thr_hs3), .thr_vs(thr_vs3), .thr_de(thr_de3),
    .stat_valid(stat_valid3), .stat_count(stat_count3), .stat_bbox(stat_bbox3));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: window boxes, frame-start swap, per-frame hit statistics.
  typedef struct { logic [NW-1:0] mask; logic hs, vs, de; } exp_t;
  exp_t q[$];
  int sh[NW][7], act[NW][7];
  int cnt[NW], bxmin[NW], bxmax[NW], bymin[NW], bymax[NW];
  int mx, my;
  bit vs1, vs2, de1;
  int fmax[7] = '{31, 31, 63, 63, 31, 31, 1};
  logic [15:0] ptab[4][8];

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    logic [4:0] rr; logic [5:0] gg; logic [4:0] bb;
    rr = 5'(r); gg = 6'(g); bb = 5'(b);
    return {rr, gg, bb};
  endfunction

  function automatic bit win_hit(input int w, input logic [15:0] d);
    int r, g, b;
    r = int'(d[15:11]); g = int'(d[10:5]); b = int'(d[4:0]);
    return act[w][6] == 1 && r >= act[w][0] && r <= act[w][1] &&
           g >= act[w][2] && g <= act[w][3] && b >= act[w][4] && b <= act[w][5];
  endfunction

  task automatic clear_acc();
    for (int w = 0; w < NW; w++) begin
      cnt[w] = 0; bxmin[w] = 2047; bxmax[w] = 0; bymin[w] = 2047; bymax[w] = 0;
    end
  endtask

  task automatic model_reset();
    exp_t z;
    for (int w = 0; w < NW; w++)
      for (int f = 0; f < 7; f++) begin
        sh[w][f]  = (f == 1 || f == 3 || f == 5) ? fmax[f] : 0;
        act[w][f] = sh[w][f];
      end
    clear_acc();
    mx = 0; my = 0; vs1 = 0; vs2 = 0; de1 = 0;
    z.mask = '0; z.hs = 0; z.vs = 0; z.de = 0;
    q.delete(); q.push_back(z); q.push_back(z);
  endtask

  task automatic step(input logic [15:0] d, input logic hs, input logic vs, input logic de,
                      input logic we, input logic [3:0] a, input logic [7:0] wd);
    bit fs;
    exp_t e;
    int sc[NW], sx0[NW], sx1[NW], sy0[NW], sy1[NW];
    fs = vs1 && !vs2;
    if (fs) begin
      for (int w = 0; w < NW; w++) begin
        sc[w] = cnt[w]; sx0[w] = bxmin[w]; sx1[w] = bxmax[w]; sy0[w] = bymin[w]; sy1[w] = bymax[w];
        for (int f = 0; f < 7; f++) act[w][f] = sh[w][f];
      end
      clear_acc();
      mx = 0; my = 0;
    end
    e.mask = '0; e.hs = hs; e.vs = vs; e.de = de;
    if (de) begin
      for (int w = 0; w < NW; w++)
        if (win_hit(w, d)) begin
          e.mask[w] = 1'b1;
          if (!(vs && !vs1)) begin
            cnt[w]++;
            if (mx < bxmin[w]) bxmin[w] = mx;
            if (mx > bxmax[w]) bxmax[w] = mx;
            if (my < bymin[w]) bymin[w] = my;
            if (my > bymax[w]) bymax[w] = my;
          end
        end
      if (mx < 2047) mx++;
    end else if (de1) begin
      mx = 0;
      if (my < 2047) my++;
    end
    if (we && a[2:0] != 3'd7 && int'(a >> 3) < NW)
      sh[int'(a >> 3)][int'(a[2:0])] = int'(wd) & fmax[int'(a[2:0])];
    q.push_back(e);
    in_data = d; in_hs = hs; in_vs = vs; in_de = de;
    cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    @(posedge clk); #1;
    e = q[q.size()-2];
    while (q.size() > 2) void'(q.pop_front());
    chk("mask", 64'(thr_data), 64'(e.mask));
    chk("mask_c3", 64'(thr_data3), 64'(e.mask));
    chk("sync", 64'({thr_hs, thr_vs, thr_de}), 64'({e.hs, e.vs, e.de}));
    chk("stat_valid", 64'(stat_valid), 64'(fs));
    chk("stat_valid_c3", 64'(stat_valid3), 64'(fs));
    if (fs)
      for (int w = 0; w < NW; w++) begin
        chk("stat_cnt", 64'(stat_count[w*CW +: CW]), 64'(sc[w] > 4194303 ? 4194303 : sc[w]));
        chk("stat_cnt_c3", 64'(stat_count3[w*3 +: 3]), 64'(sc[w] > 7 ? 7 : sc[w]));
        chk("stat_bbox", 64'(stat_bbox[w*BB +: BB]),
            64'({11'(sx0[w]), 11'(sx1[w]), 11'(sy0[w]), 11'(sy1[w])}));
      end
    vs2 = vs1; vs1 = vs; de1 = de;
    cfg_we = 1'b0;
  endtask

  task automatic idle();                 step('0, 0, 0, 0, 0, '0, '0); endtask
  task automatic pix(input logic [15:0] d); step(d, 0, 0, 1, 0, '0, '0); endtask
  task automatic cfgw(input logic [3:0] a, input logic [7:0] d); step('0, 0, 0, 0, 1, a, d); endtask

  task automatic vs_pulse();
    step('0, 0, 1, 0, 0, '0, '0); step('0, 0, 1, 0, 0, '0, '0);
    idle(); idle();
  endtask

  task automatic frame(input int rows, input int cols, input bit rnd,
                       input int cfg_row, input logic [3:0] ca, input logic [7:0] cd);
    vs_pulse();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) pix(rnd ? 16'($urandom) : ptab[r][c]);
      step('0, 1, 0, 0, r == cfg_row, ca, cd);
      step('0, 1, 0, 0, 0, '0, '0);
      step('0, 1, 0, 0, 0, '0, '0);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_thr", 64'({thr_data, thr_hs, thr_vs, thr_de}), 64'd0);
    chk("rst_stat", 64'({stat_valid, stat_count}), 64'd0);
    chk("rst_bbox0", 64'(stat_bbox[BB-1:0]), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic fill(input logic [15:0] d);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) ptab[r][c] = d;
  endtask

  task automatic win0_box();
    cfgw(4'h0, 0); cfgw(4'h1, 6); cfgw(4'h2, 0); cfgw(4'h3, 12);
    cfgw(4'h4, 0); cfgw(4'h5, 6); cfgw(4'h6, 1);
  endtask

  initial begin
    model_reset();
    do_reset(3);

    // latency and basic match
    win0_box();
    vs_pulse();
    pix(16'h0000); pix(16'hFFFF);
    chk("t1_hit", 64'(thr_data[0]), 64'd1);
    idle();
    chk("t1_miss", 64'(thr_data[0]), 64'd0);
    chk("t1_de", 64'(thr_de), 64'd1);
    idle();

    // inclusive edges, inverted window, ignored field 7
    pix(rgb(6, 12, 6)); pix(rgb(7, 12, 6));
    chk("t2_edge_hit", 64'(thr_data[0]), 64'd1);
    idle();
    chk("t2_edge_miss", 64'(thr_data[0]), 64'd0);
    cfgw(4'h8, 9); cfgw(4'h9, 3); cfgw(4'hE, 1); cfgw(4'h7, 8'hFF);
    vs_pulse();
    for (int r = 0; r < 32; r++) begin
      pix(rgb(r, 0, 0));
      chk("t2_inv", 64'(thr_data[1]), 64'd0);
    end
    idle(); idle();

    // 4x3 frame, two hits
    fill(16'hFFFF); ptab[0][1] = rgb(1, 1, 1); ptab[2][3] = rgb(1, 1, 1);
    frame(3, 4, 0, -1, '0, '0);
    vs_pulse();
    chk("t3_cnt", 64'(stat_count[CW-1:0]), 64'd2);
    chk("t3_bbox", 64'(stat_bbox[BB-1:0]), 64'({11'd1, 11'd3, 11'd0, 11'd2}));

    // shadow write mid-frame only applies after the next frame start
    fill(rgb(20, 0, 0));
    frame(3, 4, 0, 1, 4'h1, 8'd31);
    vs_pulse();
    chk("t4_before", 64'(stat_count[CW-1:0]), 64'd0);
    frame(3, 4, 0, -1, '0, '0);
    vs_pulse();
    chk("t4_after", 64'(stat_count[CW-1:0]), 64'd12);

    // empty frame, hits with de low ignored
    fill(16'hFFFF);
    frame(2, 4, 0, -1, '0, '0);
    step(rgb(1, 1, 1), 0, 0, 0, 0, '0, '0); step(rgb(1, 1, 1), 0, 0, 0, 0, '0, '0);
    vs_pulse();
    chk("t5_cnt", 64'(stat_count[CW-1:0]), 64'd0);
    chk("t5_bbox", 64'(stat_bbox[BB-1:0]), 64'({11'h7FF, 11'd0, 11'h7FF, 11'd0}));

    // mid-frame reset, then saturating counter
    vs_pulse();
    pix(rgb(1, 1, 1)); pix(rgb(1, 1, 1));
    do_reset(1);
    pix(rgb(1, 1, 1)); pix(rgb(1, 1, 1)); idle(); idle(); idle();
    win0_box();
    fill(rgb(1, 1, 1));
    frame(2, 5, 0, -1, '0, '0);
    vs_pulse();
    chk("t6_cnt", 64'(stat_count[CW-1:0]), 64'd10);
    chk("t6_cnt_sat", 64'(stat_count3[2:0]), 64'd7);
    chk("t6_bbox", 64'(stat_bbox[BB-1:0]), 64'({11'd0, 11'd4, 11'd0, 11'd1}));

    // random windows and pixels
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < NW; w++)
        for (int f = 0; f < 6; f += 2) begin
          cfgw(4'(w*8 + f), 8'($urandom_range(0, fmax[f] / 2)));
          cfgw(4'(w*8 + f + 1), 8'($urandom_range(fmax[f] / 2, fmax[f])));
        end
      cfgw(4'h6, 8'($urandom_range(0, 1)));
      cfgw(4'hE, 8'(1));
      frame($urandom_range(2, 4), $urandom_range(3, 8), 1, -1, '0, '0);
    end
    vs_pulse();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
